// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the registered signed ALU.
//   OP_* : 3-bit opcode encodings
//   NIO_DEFAULT : default data width
//   smax/smin : signed range limits used when clamping overflowed results
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam int NIO_DEFAULT = 8;

    // Largest positive value of a w-bit two's-complement number.
    function automatic longint smax(input int w);
        return (longint'(1) << (w - 1)) - longint'(1);
    endfunction

    // Most negative value of a w-bit two's-complement number.
    function automatic longint smin(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

endpackage

// File: rtl/alu_if.sv
// alu_if -- operand/result bundle of the ALU.
//   A, B : signed operands (B low bits also carry the shift amount)
//   OP   : opcode
//   Z    : registered signed result
//   OV   : registered signed-overflow flag
// master drives operands and reads results; slave is the ALU side.
interface alu_if
    import alu_pkg::*;
#(
    parameter int NIO = NIO_DEFAULT
);
    logic signed [NIO-1:0] A;
    logic signed [NIO-1:0] B;
    logic [2:0]            OP;
    logic signed [NIO-1:0] Z;
    logic                  OV;

    modport master (output A, output B, output OP, input Z, input OV);
    modport slave  (input A, input B, input OP, output Z, output OV);
endinterface

// File: rtl/alu_addsub.sv
// alu_addsub -- combinational signed adder/subtractor.
//   a, b : signed operands
//   sub  : 0 -> a + b, 1 -> a - b
//   sum  : wrapped result
//   ov   : signed overflow of the selected operation
module alu_addsub
    import alu_pkg::*;
#(
    parameter int NIO = NIO_DEFAULT
) (
    input  logic signed [NIO-1:0] a,
    input  logic signed [NIO-1:0] b,
    input  logic                  sub,
    output logic signed [NIO-1:0] sum,
    output logic                  ov
);
    // Sign of the effective second operand: subtraction adds -b, so the
    // overflow test compares against the inverted sign of b.
    logic b_sign_eff;

    assign sum        = sub ? (a - b) : (a + b);
    assign b_sign_eff = sub ? ~b[NIO-1] : b[NIO-1];
    assign ov         = (a[NIO-1] == b_sign_eff) && (sum[NIO-1] != a[NIO-1]);
endmodule

// File: rtl/alu.sv
// alu -- registered signed two's-complement ALU with overflow flag.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears Z and OV
//   bus : alu_if slave (A, B, OP in; Z, OV out, one cycle after sampling)
// Optional build macro ALU_SATURATE_EN: ADD/SUB/MUL/SHL results that
// overflow are clamped to the signed limit matching the true result's sign.
module alu
    import alu_pkg::*;
#(
    parameter int NIO = NIO_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    alu_if.slave     bus
);
    localparam int SW = $clog2(NIO);
    localparam logic signed [NIO-1:0] MAXV = NIO'(smax(NIO));
    localparam logic signed [NIO-1:0] MINV = NIO'(smin(NIO));
`ifdef ALU_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Replace an overflowed result by the limit on the side of the true result.
    function automatic logic signed [NIO-1:0] sat(
        input logic signed [NIO-1:0] wrapped,
        input logic                  ovf,
        input logic                  neg
    );
        if (SAT_EN && ovf) return neg ? MINV : MAXV;
        return wrapped;
    endfunction

    logic signed [NIO-1:0]   as_sum;
    logic                    as_ov;
    logic signed [2*NIO-1:0] prod;
    logic                    prod_ov;
    logic [SW-1:0]           sh;
    logic signed [NIO-1:0]   shl;
    logic                    shl_ov;
    logic signed [NIO-1:0]   res_p0;
    logic                    ov_p0;
    logic signed [NIO-1:0]   z_p1;
    logic                    ov_p1;

    alu_addsub #(.NIO(NIO)) u_addsub (
        .a   (bus.A),
        .b   (bus.B),
        .sub (bus.OP == OP_SUB),
        .sum (as_sum),
        .ov  (as_ov)
    );

    assign prod = (2*NIO)'(bus.A) * (2*NIO)'(bus.B);
    // The product fits in NIO bits only if its top NIO+1 bits are all equal.
    assign prod_ov = !((&prod[2*NIO-1:NIO-1]) || !(|prod[2*NIO-1:NIO-1]));

    assign sh     = bus.B[SW-1:0];
    assign shl    = bus.A << sh;
    // Shifting back arithmetically recovers A only if nothing significant fell off.
    assign shl_ov = (shl >>> sh) != bus.A;

    // Stage p0: combinational result selection
    always_comb begin
        res_p0 = '0;
        ov_p0  = 1'b0;
        case (bus.OP)
            OP_ADD, OP_SUB: begin
                // Add/sub overflow only happens when the true result has A's sign.
                res_p0 = sat(as_sum, as_ov, bus.A[NIO-1]);
                ov_p0  = as_ov;
            end
            OP_MUL: begin
                res_p0 = sat(prod[NIO-1:0], prod_ov, prod[2*NIO-1]);
                ov_p0  = prod_ov;
            end
            OP_AND: res_p0 = bus.A & bus.B;
            OP_OR:  res_p0 = bus.A | bus.B;
            OP_XOR: res_p0 = bus.A ^ bus.B;
            OP_SHL: begin
                res_p0 = sat(shl, shl_ov, bus.A[NIO-1]);
                ov_p0  = shl_ov;
            end
            OP_SRA: res_p0 = bus.A >>> sh;
            default: begin
                res_p0 = '0;
                ov_p0  = 1'b0;
            end
        endcase
    end

    // Stage p1: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            z_p1  <= '0;
            ov_p1 <= 1'b0;
        end else begin
            z_p1  <= res_p0;
            ov_p1 <= ov_p0;
        end
    end

    assign bus.Z  = z_p1;
    assign bus.OV = ov_p1;
endmodule

// File: tb/tb_alu.sv
// tb_alu -- self-checking bench for the 8-bit alu: directed cases plus
// randomized back-to-back operations compared against an integer model.
module tb_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    alu_if #(.NIO(8)) bus ();

    alu #(.NIO(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef ALU_SATURATE_EN
    localparam int E_ADD_HI = 127;
    localparam int E_ADD_LO = -128;
    localparam int E_SUB_HI = 127;
    localparam int E_MUL_NN = 127;
    localparam int E_MUL_SQ = 127;
    localparam int E_SHL_HI = 127;
`else
    localparam int E_ADD_HI = -106;
    localparam int E_ADD_LO = 0;
    localparam int E_SUB_HI = -128;
    localparam int E_MUL_NN = -128;
    localparam int E_MUL_SQ = 0;
    localparam int E_SHL_HI = -128;
`endif

    // Integer reference: compute the exact result, flag it when it leaves
    // the 8-bit signed range, then clamp or wrap.
    task automatic model(input logic [2:0] op, input int a, input int b,
                         output int z, output bit ov);
        int t;
        int s;
        bit arith;
        s     = b & 7;
        t     = 0;
        arith = 1'b0;
        ov    = 1'b0;
        case (op)
            OP_ADD: begin t = a + b;        arith = 1'b1; end
            OP_SUB: begin t = a - b;        arith = 1'b1; end
            OP_MUL: begin t = a * b;        arith = 1'b1; end
            OP_AND: t = a & b;
            OP_OR:  t = a | b;
            OP_XOR: t = a ^ b;
            OP_SHL: begin t = a * (1 << s); arith = 1'b1; end
            default: t = a >>> s;
        endcase
        if (arith) ov = (t > 127) || (t < -128);
`ifdef ALU_SATURATE_EN
        if (ov) t = (t < 0) ? -128 : 127;
`endif
        z = int'(byte'(t));
    endtask

    task automatic check(input string tag, input int z_exp, input bit ov_exp);
        logic signed [7:0] ze;
        logic              oe;
        ze = 8'(z_exp);
        oe = ov_exp;
        total++;
        assert (bus.Z === ze) else begin
            bad++;
            $error("FAIL %s Z got=%0d want=%0d", tag, bus.Z, ze);
        end
        total++;
        assert (bus.OV === oe) else begin
            bad++;
            $error("FAIL %s OV got=%0b want=%0b", tag, bus.OV, oe);
        end
    endtask

    // Drive one operation right after an edge, then check one edge later.
    task automatic step(input logic [2:0] op, input int a, input int b,
                        input int z_exp, input bit ov_exp, input string tag);
        bus.OP = op;
        bus.A  = 8'(a);
        bus.B  = 8'(b);
        @(posedge clk);
        #1;
        check(tag, z_exp, ov_exp);
    endtask

    initial begin
        int  zm;
        bit  om;
        logic [2:0] op;
        int  a;
        int  b;

        rst    = 1'b1;
        bus.OP = OP_ADD;
        bus.A  = 8'sd5;
        bus.B  = 8'sd3;
        @(posedge clk); #1;
        check("reset1", 0, 1'b0);
        @(posedge clk); #1;
        check("reset2", 0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_reset", 8, 1'b0);

        step(OP_ADD, 100, 50, E_ADD_HI, 1'b1, "add_pos_ovf");
        step(OP_ADD, -20, 7, -13, 1'b0, "add_mixed");
        step(OP_ADD, -128, -128, E_ADD_LO, 1'b1, "add_min_min");
        step(OP_SUB, 0, -128, E_SUB_HI, 1'b1, "sub_0_min");
        step(OP_SUB, 50, 20, 30, 1'b0, "sub_plain");
        step(OP_MUL, -12, 10, -120, 1'b0, "mul_fit");
        step(OP_MUL, 16, 16, E_MUL_SQ, 1'b1, "mul_16x16");
        step(OP_MUL, -128, -1, E_MUL_NN, 1'b1, "mul_min_neg1");
        step(OP_AND, 'hF0, 'h3C, 'h30 - 0, 1'b0, "and");
        step(OP_OR,  'hF0, 'h3C, -4, 1'b0, "or");
        step(OP_XOR, 'hF0, 'h3C, -52, 1'b0, "xor");
        step(OP_SHL, 3, 5, 96, 1'b0, "shl_3_5");
        step(OP_SHL, 64, 1, E_SHL_HI, 1'b1, "shl_64_1");
        step(OP_SRA, -64, 3, -8, 1'b0, "sra_neg");
        step(OP_SHL, -77, 8, -77, 1'b0, "shl_zero_amt");
        step(OP_SRA, 99, 16, 99, 1'b0, "sra_zero_amt");

        // Reset discards the operation sampled at the same edge.
        bus.OP = OP_ADD;
        bus.A  = 8'sd10;
        bus.B  = 8'sd10;
        rst    = 1'b1;
        @(posedge clk); #1;
        check("reset_inflight", 0, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_inflight", 20, 1'b0);

        // Back-to-back: new opcode every cycle, one-cycle latency.
        for (int i = 0; i < 40; i++) begin
            op = (i < 16) ? 3'(i) : 3'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 255)) - 128;
            b  = int'($urandom_range(0, 255)) - 128;
            model(op, a, b, zm, om);
            step(op, a, b, zm, om, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
